// File: rtl/note_pkg.sv
// Shared types, chart-word field positions and saturating helpers for the per-lane note scheduler.
package note_pkg;

    typedef enum logic [1:0] {
        NT_TAP       = 2'b00,
        NT_HOLD_HEAD = 2'b01,
        NT_HOLD_TAIL = 2'b10,
        NT_END       = 2'b11
    } note_type_e;

    typedef enum logic [1:0] {
        J_NONE    = 2'b00,
        J_PERFECT = 2'b01,
        J_GOOD    = 2'b10,
        J_MISS    = 2'b11
    } judge_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } sched_state_e;

    localparam int TYPE_MSB = 15;
    localparam int TYPE_LSB = 14;
    localparam int TIME_W   = 14;

    localparam logic [7:0] DEF_NUM_NOTES   = 8'd148;
    localparam logic [3:0] DEF_PERFECT_WIN = 4'd3;
    localparam logic [3:0] DEF_GOOD_WIN    = 4'd6;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] c);
        return (c == 10'h3FF) ? c : c + 10'd1;
    endfunction

endpackage

// File: rtl/note_judge.sv
// Combinational timing classifier: places a signed frame offset relative to the hit windows.
module note_judge (
    input  logic signed [14:0] dt_i,
    input  logic        [3:0]  perfect_win_i,
    input  logic        [3:0]  good_win_i,
    output logic               in_window_o,
    output logic               early_o,
    output logic               late_o,
    output logic               perfect_o
);

    logic signed [14:0] good_s;
    logic signed [14:0] perf_s;

    // Windows are symmetric around the note timestamp.
    always_comb begin
        good_s      = $signed({11'd0, good_win_i});
        perf_s      = $signed({11'd0, perfect_win_i});
        late_o      = (dt_i > good_s);
        early_o     = (dt_i < -good_s);
        in_window_o = !late_o && !early_o;
        perfect_o   = (dt_i <= perf_s) && (dt_i >= -perf_s);
    end

endmodule

// File: rtl/note_scheduler.sv
// Per-lane chart sequencer: walks the note ROM, judges key timing, tracks holds, score and combo.
// Optional build macro AUTOPLAY_EN replaces the key inputs with an internal perfect player.
module note_scheduler
    import note_pkg::*;
#(
    parameter logic [7:0] NUM_NOTES   = DEF_NUM_NOTES,
    parameter logic [3:0] PERFECT_WIN = DEF_PERFECT_WIN,
    parameter logic [3:0] GOOD_WIN    = DEF_GOOD_WIN
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic        pause,
    input  logic        frame_tick,
    input  logic        key_press,
    input  logic        key_held,
    input  logic [15:0] note_word,
    output logic [7:0]  rom_addr,
    output logic        judge_valid,
    output logic [1:0]  judge,
    output logic        hold_active,
    output logic [15:0] score,
    output logic [9:0]  combo,
    output logic        done
);

    sched_state_e state_q, state_d;
    logic [7:0]   addr_q, addr_d;
    logic [13:0]  frame_q, frame_d;
    logic [15:0]  score_q, score_d;
    logic [9:0]   combo_q, combo_d;
    judge_e       judge_q, judge_d;
    logic         judge_valid_q, judge_valid_d;
    logic         hold_active_q, hold_active_d;
    logic         done_q, done_d;

    judge_e       verdict_s;
    logic         restart_s;
    note_type_e   head_type_s;
    logic [TIME_W-1:0] head_time_s;
    logic signed [14:0] dt_s;
    logic         press_s, held_s;
    logic         in_window_s, early_s, late_s, perfect_s;

    assign head_type_s = note_type_e'(note_word[TYPE_MSB:TYPE_LSB]);
    assign head_time_s = note_word[TIME_W-1:0];
    assign dt_s        = $signed({1'b0, frame_q}) - $signed({1'b0, head_time_s});

`ifdef AUTOPLAY_EN
    // The built-in player hits every head exactly on time and never lets go of a hold.
    assign press_s = (dt_s == 15'sd0);
    assign held_s  = 1'b1;
`else
    assign press_s = key_press;
    assign held_s  = key_held;
`endif

    note_judge u_judge (
        .dt_i          (dt_s),
        .perfect_win_i (PERFECT_WIN),
        .good_win_i    (GOOD_WIN),
        .in_window_o   (in_window_s),
        .early_o       (early_s),
        .late_o        (late_s),
        .perfect_o     (perfect_s)
    );

    // State register and all registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= S_IDLE;
            addr_q        <= 8'd0;
            frame_q       <= 14'd0;
            score_q       <= 16'd0;
            combo_q       <= 10'd0;
            judge_q       <= J_NONE;
            judge_valid_q <= 1'b0;
            hold_active_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            frame_q       <= frame_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            judge_q       <= judge_d;
            judge_valid_q <= judge_valid_d;
            hold_active_q <= hold_active_d;
            done_q        <= done_d;
        end
    end

    // Next-state: pointer movement and the single verdict for this cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        verdict_s = J_NONE;
        restart_s = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    restart_s = 1'b1;
                end else begin
                    restart_s = 1'b0;
                end
            end
            S_RUN: begin
                if (start) begin
                    restart_s = 1'b1;
                end else if ((addr_q >= NUM_NOTES) || (head_type_s == NT_END)) begin
                    state_d = S_DONE;
                end else if (!pause) begin
                    case (head_type_s)
                        NT_TAP, NT_HOLD_HEAD: begin
                            if (press_s && in_window_s) begin
                                verdict_s = perfect_s ? J_PERFECT : J_GOOD;
                                addr_d    = addr_q + 8'd1;
                                state_d   = (head_type_s == NT_HOLD_HEAD) ? S_HOLD : S_RUN;
                            end else if (late_s) begin
                                // A missed hold head also discards its tail.
                                verdict_s = J_MISS;
                                addr_d    = addr_q + ((head_type_s == NT_HOLD_HEAD) ? 8'd2 : 8'd1);
                            end else begin
                                verdict_s = J_NONE;
                            end
                        end
                        NT_HOLD_TAIL: addr_d = addr_q + 8'd1;
                        default:      addr_d = addr_q;
                    endcase
                end else begin
                    verdict_s = J_NONE;
                end
            end
            S_HOLD: begin
                if (start) begin
                    restart_s = 1'b1;
                end else if (!pause) begin
                    if (head_type_s == NT_HOLD_TAIL) begin
                        if (held_s && !dt_s[14]) begin
                            verdict_s = J_PERFECT;
                        end else if (!held_s) begin
                            verdict_s = early_s ? J_MISS : J_GOOD;
                        end else begin
                            verdict_s = J_NONE;
                        end
                        if (verdict_s != J_NONE) begin
                            addr_d  = addr_q + 8'd1;
                            state_d = S_RUN;
                        end else begin
                            addr_d = addr_q;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    verdict_s = J_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (restart_s) begin
            state_d = S_RUN;
            addr_d  = 8'd0;
        end else begin
            restart_s = 1'b0;
        end
    end

    // Frame clock, score/combo accounting and strobe generation.
    always_comb begin
        frame_d       = frame_q;
        score_d       = score_q;
        combo_d       = combo_q;
        judge_d       = verdict_s;
        judge_valid_d = (verdict_s != J_NONE);
        hold_active_d = (state_d == S_HOLD);
        done_d        = (state_d == S_DONE);
        if (restart_s) begin
            frame_d = 14'd0;
            score_d = 16'd0;
            combo_d = 10'd0;
        end else begin
            if (((state_q == S_RUN) || (state_q == S_HOLD)) && !pause && frame_tick
                && (frame_q != 14'h3FFF)) begin
                frame_d = frame_q + 14'd1;
            end else begin
                frame_d = frame_q;
            end
            case (verdict_s)
                J_PERFECT: begin
                    score_d = sat_add16(score_q, 16'd2);
                    combo_d = sat_inc10(combo_q);
                end
                J_GOOD: begin
                    score_d = sat_add16(score_q, 16'd1);
                    combo_d = sat_inc10(combo_q);
                end
                J_MISS:  combo_d = 10'd0;
                default: combo_d = combo_q;
            endcase
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        rom_addr    = addr_q;
        judge_valid = judge_valid_q;
        judge       = judge_q;
        hold_active = hold_active_q;
        score       = score_q;
        combo       = combo_q;
        done        = done_q;
    end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Per-lane chart sequencer for the rhythm-game datapath.
- Owns the read pointer into one lane's note-chart ROM.
- Keeps the song frame clock, compares the head note's timestamp with the player's key input, and issues judgements (perfect/good/miss).
- Tracks hold notes, score and combo; one instance per lane, which feeds the lane renderer and the score display.

Parameters:
- NUM_NOTES, 8'd148: valid chart entries; pointer reaching this value ends the lane.
- PERFECT_WIN, 4'd3: |dt| ≤ this (frames) → perfect.
- GOOD_WIN, 4'd6: |dt| ≤ this (frames) → good; dt > GOOD_WIN → miss.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin/restart song
- pause  in  1  level; freezes frame clock and judgement
- frame_tick  in  1  one-cycle pulse per 60 Hz frame
- key_press  in  1  one-cycle pulse on lane key down
- key_held  in  1  lane key level
- note_word  in  16  ROM data at rom_addr (combinational ROM); [15:14] type, [13:0] timestamp in frames
- rom_addr  out  8  chart pointer
- judge_valid  out  1  one-cycle judgement strobe
- judge  out  2  01 perfect, 10 good, 11 miss
- hold_active  out  1  hold in progress
- score  out  16  saturating score
- combo  out  10  current combo, saturating
- done  out  1  lane finished

Behaviour:
- Reset: rom_addr=0, frame=0, score=0, combo=0, judge=00, judge_valid=0, hold_active=0, done=0, state IDLE.
- Note types: 00 tap, 01 hold head, 10 hold tail, 11 end marker.
- dt = frame − timestamp, 15-bit signed.
- Frame clock: 14-bit; +1 on frame_tick in RUN/HOLD when pause=0; saturates at 14'h3FFF.
- IDLE: outputs held. start → RUN with frame=0, addr=0, score=0, combo=0.
- RUN, head tap or head hold:
  - key_press with |dt| ≤ GOOD_WIN → judge (perfect if |dt| ≤ PERFECT_WIN, else good); addr+1.
  - If the head was type 01 → HOLD; hold_active=1 from the next cycle.
  - key_press with dt < −GOOD_WIN → ignored.
  - dt > GOOD_WIN → miss. Tap: addr+1. Hold head: addr+2, skipping the tail.
- RUN, head type 10 (orphan tail): addr+1, no judgement.
- RUN, head type 11, or addr==NUM_NOTES: → DONE.
- HOLD, head is tail:
  - key_held=1 and dt ≥ 0 → perfect.
  - key_held falls with dt ≥ −GOOD_WIN → good.
  - key_held falls earlier → miss.
  - On any of these: addr+1, hold_active=0, → RUN.
- DONE: done=1, addr frozen. start → restart as from IDLE.
- Judgement timing:
  - judge/judge_valid are registered, asserted the cycle after the decision.
  - At most one judgement per cycle.
  - New head evaluated the cycle after the addr update.
  - key_press in the advancing cycle is consumed only by the current note.
- Score: perfect +2, good +1, saturating at 16'hFFFF.
- Combo: +1 on perfect/good, saturating at 1023; cleared on miss.
- pause=1: no judgements, no misses, no frame increments; key_press dropped.
- start during RUN/HOLD: immediate restart; hold_active=0.
- Reset mid-song: all state returns to reset values.

Optional Feature:
- AUTOPLAY_EN defined: key_press/key_held ignored.
  - Scheduler presses at dt==0 on taps and heads, holds through tails.
  - Every note judged perfect.
- Undefined: key inputs as above; no autoplay logic synthesized.

Decomposition:
- note_pkg:
  - note_type_e (TAP, HOLD_HEAD, HOLD_TAIL, END).
  - judge_e (NONE, PERFECT, GOOD, MISS).
  - field positions TYPE_MSB=15, TYPE_LSB=14, TIME_W=14.
  - sched_state_e (IDLE, RUN, HOLD, DONE).
- Sub-module note_judge: combinational; takes dt and window parameters, returns in_window, early, late, perfect.

Test Plan:
- Tap 16'h0032 (t=50), key_press at frame 50 → judge=01 next cycle, score=2, combo=1, rom_addr=1.
- Same tap, press at frame 55 → judge=10, score=1. No press → miss strobe at frame 57, combo=0, rom_addr=1.
- Hold 16'h411A / 16'h8143 (t=282/323), press at 282, hold to 323 → perfect, hold_active 1→0, addr+2 total, score=4.
- Same hold, release at frame 300 → tail miss, combo cleared. Head never pressed → single miss, addr+2.
- pause=1 across frames 45–60 with tail t=50 → no miss, frame stays 45. Unpause, press within window → perfect.
- Head type 11 (16'hC000) or addr=NUM_NOTES → done=1 and stays; start → rom_addr=0, score=0, done=0.
